// File: rtl/calc_sequencer.sv
// Controller for the 4-digit BCD calculator: digit entry, operand load, shift-add multiply /
// restoring divide, double-dabble conversion and result display sequencing.
module calc_sequencer #(
  parameter int unsigned WRAP_DIGIT = 9,
  parameter bit          DIV_ROUND  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_pulse,
  input  logic [1:0]  op,
  input  logic        calc_go,
  input  logic        clear,
  output logic [15:0] digits_in,
  output logic [15:0] digits_out,
  output logic        show_result,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam logic [3:0] WRAP   = 4'(WRAP_DIGIT);

  typedef enum logic [2:0] {S_ENTRY, S_LOAD, S_EXEC, S_CONV, S_SHOW} state_t;

  state_t state, state_next;

  logic [3:0][3:0] digit;
  logic [6:0]  num1_in, num2_in, num1_q, num2_q;
  logic [1:0]  op_q;
  logic [3:0]  cnt;
  logic [13:0] acc, mcand, acc_next, exec_result, bin;
  logic [6:0]  mplier;
  logic [8:0]  rem, dvd, dvsr, quo, rem_next, quo_next;
  logic [9:0]  trial;
  logic [15:0] bcd;
  logic [29:0] dd_next;
  logic        neg, exec_neg, exec_last, div_zero, div_ge, entering_show;

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d == WRAP) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step: adjust every BCD nibble, then shift {bcd,bin} left by one.
  function automatic logic [29:0] dabble_step(input logic [15:0] b, input logic [13:0] x);
    logic [15:0] a;
    a = {add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
    return {a[14:0], x, 1'b0};
  endfunction

  function automatic logic [15:0] fmt_result(input logic [15:0] b, input logic n);
    return n ? {4'd11, 4'd10, b[7:0]} : b;
  endfunction

  assign digits_in   = digit;
  assign num1_in     = 7'(digit[3]) * 7'd10 + 7'(digit[2]);
  assign num2_in     = 7'(digit[1]) * 7'd10 + 7'(digit[0]);
  assign busy        = (state == S_LOAD) || (state == S_EXEC) || (state == S_CONV);
  assign show_result = (state == S_SHOW);
  assign div_zero    = (state == S_EXEC) && (op_q == OP_DIV) && (num2_q == 7'd0);
  assign entering_show = (state_next == S_SHOW) && (state != S_SHOW);

  always_comb begin
    acc_next    = acc + (mplier[0] ? mcand : 14'd0);
    trial       = {rem, dvd[8]};
    div_ge      = (trial >= {1'b0, dvsr});
    rem_next    = div_ge ? 9'(trial - {1'b0, dvsr}) : trial[8:0];
    quo_next    = {quo[7:0], div_ge};
    dd_next     = dabble_step(bcd, bin);
    exec_result = 14'd0;
    exec_neg    = 1'b0;
    exec_last   = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_result = 14'(num1_q) + 14'(num2_q);
        exec_last   = 1'b1;
      end
      OP_SUB: begin
        if (num1_q >= num2_q) begin
          exec_result = 14'(num1_q - num2_q);
        end else begin
          exec_result = 14'(num2_q - num1_q);
          exec_neg    = 1'b1;
        end
        exec_last = 1'b1;
      end
      OP_MUL: begin
        exec_result = acc_next;
        exec_last   = (cnt == 4'd6);
      end
      default: begin
        exec_result = 14'(quo_next);
        exec_last   = (cnt == 4'd8);
      end
    endcase
    if (state != S_EXEC) exec_last = 1'b0;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_ENTRY;
    end else begin
      case (state)
        S_ENTRY: if (calc_go) state_next = S_LOAD;
        S_LOAD:  state_next = S_EXEC;
        S_EXEC: begin
          if (div_zero)       state_next = S_SHOW;
          else if (exec_last) state_next = S_CONV;
        end
        S_CONV:  if (cnt == 4'd13) state_next = S_SHOW;
        S_SHOW: begin
          if (calc_go)           state_next = S_LOAD;
          else if (|digit_pulse) state_next = S_ENTRY;
        end
        default: state_next = S_ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_ENTRY;
    else     state <= state_next;
  end

  // Control and visible outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      digit      <= '0;
      digits_out <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= entering_show;
      err  <= (state_next == S_SHOW) && (div_zero || err);
      if (entering_show)
        digits_out <= div_zero ? 16'hAAAA : fmt_result(dd_next[29:14], neg);
      if (clear) begin
        digit <= '0;
      end else if ((state == S_ENTRY) && !calc_go) begin
        if (digit_pulse[3])      digit[3] <= inc_digit(digit[3]);
        else if (digit_pulse[2]) digit[2] <= inc_digit(digit[2]);
        else if (digit_pulse[1]) digit[1] <= inc_digit(digit[1]);
        else if (digit_pulse[0]) digit[0] <= inc_digit(digit[0]);
      end
      if (((state == S_EXEC) && !exec_last) || (state == S_CONV)) cnt <= cnt + 4'd1;
      else                                                         cnt <= '0;
    end
  end

  // Arithmetic datapath
  always_ff @(posedge clk) begin
    case (state)
      S_LOAD: begin
        num1_q <= num1_in;
        num2_q <= num2_in;
        op_q   <= op;
        acc    <= '0;
        mcand  <= 14'(num1_in);
        mplier <= num2_in;
        rem    <= '0;
        quo    <= '0;
        dvd    <= DIV_ROUND ? 9'({num1_in, 1'b0}) + 9'(num2_in) : 9'(num1_in);
        dvsr   <= DIV_ROUND ? 9'({num2_in, 1'b0}) : 9'(num2_in);
      end
      S_EXEC: begin
        acc    <= acc_next;
        mcand  <= {mcand[12:0], 1'b0};
        mplier <= {1'b0, mplier[6:1]};
        rem    <= rem_next;
        quo    <= quo_next;
        dvd    <= {dvd[7:0], 1'b0};
        if (exec_last) begin
          bin <= exec_result;
          bcd <= '0;
          neg <= exec_neg;
        end
      end
      S_CONV: {bcd, bin} <= dd_next;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: directed operand/op vectors push expected results,
// a monitor pops and compares on every done pulse.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst, calc_go, clear;
  logic [3:0]  digit_pulse;
  logic [1:0]  op;
  logic [15:0] digits_in, digits_out;
  logic        show_result, busy, done, err;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .digit_pulse(digit_pulse), .op(op), .calc_go(calc_go),
    .clear(clear), .digits_in(digits_in), .digits_out(digits_out),
    .show_result(show_result), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] dig;
    logic        e;
    int          lat;
    int          go_cyc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
      end else begin
        e = sbq.pop_front();
        check("digits_out", {16'h0, digits_out}, {16'h0, e.dig});
        check("err_at_done", {31'h0, err}, {31'h0, e.e});
        check("latency", cyc - e.go_cyc, e.lat);
        check("show_at_done", {31'h0, show_result}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx, input int n);
    if (n > 0) begin
      digit_pulse = 4'(1 << idx);
      repeat (n) tick();
      digit_pulse = 4'd0;
    end
  endtask

  task automatic set_ops(input int a, input int b);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    press(3, a / 10);
    press(2, a % 10);
    press(1, b / 10);
    press(0, b % 10);
    check("digits_in_entry", {16'h0, digits_in},
          {16'h0, 4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10)});
  endtask

  task automatic issue(input logic [1:0] o, input logic [15:0] dig, input logic e, input int lat);
    exp_t x;
    op       = o;
    x.dig    = dig;
    x.e      = e;
    x.lat    = lat;
    x.go_cyc = cyc;
    sbq.push_back(x);
    calc_go = 1'b1;
    tick();
    calc_go = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (sbq.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    check("done_timeout_pending", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; digit_pulse = 4'd0; op = 2'd0; calc_go = 1'b0; clear = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_digits_in",  {16'h0, digits_in},  32'h0);
    check("rst_digits_out", {16'h0, digits_out}, 32'h0);
    check("rst_show",       {31'h0, show_result}, 32'h0);
    check("rst_busy",       {31'h0, busy}, 32'h0);
    check("rst_done",       {31'h0, done}, 32'h0);
    check("rst_err",        {31'h0, err},  32'h0);

    // add / sub
    set_ops(23, 14); issue(2'b00, 16'h0037, 1'b0, 17); wait_done();
    set_ops(14, 23); issue(2'b01, 16'hBA09, 1'b0, 17); wait_done();
    set_ops(23, 23); issue(2'b01, 16'h0000, 1'b0, 17); wait_done();

    // mul
    set_ops(99, 99); issue(2'b10, 16'h9801, 1'b0, 23); wait_done();
    set_ops(0, 57);  issue(2'b10, 16'h0000, 1'b0, 23); wait_done();

    // div, then recompute from SHOW with a new op on the same digits
    set_ops(50, 7);  issue(2'b11, 16'h0007, 1'b0, 25); wait_done();
    set_ops(99, 2);  issue(2'b11, 16'h0050, 1'b0, 25); wait_done();
    issue(2'b00, 16'h0101, 1'b0, 17); wait_done();

    // divide by zero: err holds in SHOW, a digit pulse leaves SHOW without editing digits
    set_ops(5, 0);   issue(2'b11, 16'hAAAA, 1'b1, 3); wait_done();
    check("dz_err_held", {31'h0, err}, 32'd1);
    check("dz_show_held", {31'h0, show_result}, 32'd1);
    digit_pulse = 4'b0001;
    tick();
    digit_pulse = 4'd0;
    check("dz_exit_err", {31'h0, err}, 32'd0);
    check("dz_exit_show", {31'h0, show_result}, 32'd0);
    check("dz_exit_digits", {16'h0, digits_in}, 32'h0500);
    check("dz_exit_out", {16'h0, digits_out}, 32'hAAAA);

    // wrap, priority of highest set digit, pulses and calc_go ignored while busy
    clear = 1'b1; tick(); clear = 1'b0;
    press(0, 10);
    check("wrap_d0", {16'h0, digits_in}, 32'h0000);
    press(0, 3);
    digit_pulse = 4'b1001;
    tick();
    digit_pulse = 4'd0;
    check("prio_d3", {16'h0, digits_in}, 32'h1003);
    issue(2'b00, 16'h0013, 1'b0, 17);
    digit_pulse = 4'hF;
    tick();
    calc_go = 1'b1;
    tick();
    calc_go = 1'b0;
    repeat (3) tick();
    digit_pulse = 4'd0;
    check("busy_flag", {31'h0, busy}, 32'd1);
    check("busy_digits", {16'h0, digits_in}, 32'h1003);
    wait_done();

    // clear during a multiply aborts it with no done
    set_ops(12, 34);
    op = 2'b10;
    calc_go = 1'b1; tick(); calc_go = 1'b0;
    repeat (8) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_busy", {31'h0, busy}, 32'd0);
    check("clr_show", {31'h0, show_result}, 32'd0);
    check("clr_digits_in", {16'h0, digits_in}, 32'h0);
    check("clr_digits_out", {16'h0, digits_out}, 32'h0013);
    repeat (30) tick();

    // reset while showing a result
    set_ops(1, 1); issue(2'b00, 16'h0002, 1'b0, 17); wait_done();
    check("pre_rst_show", {31'h0, show_result}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_digits_in",  {16'h0, digits_in},  32'h0);
    check("rst2_digits_out", {16'h0, digits_out}, 32'h0);
    check("rst2_show",       {31'h0, show_result}, 32'h0);
    check("rst2_busy",       {31'h0, busy}, 32'h0);
    check("rst2_done",       {31'h0, done}, 32'h0);
    check("rst2_err",        {31'h0, err},  32'h0);

    check("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
